// File: rtl/alu32_bit.sv
// alu32_bit: MIPS execute-stage ALU-control decode, registered 32-bit ALU and a free combinational adder; ALU_EXT_OPS_EN adds XOR/SRA/SLTU.
// Latency: alu_ctrl/result/zero/overflow one cycle after sampling, add_sum combinational; no backpressure, one op per cycle.
module alu32_bit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       alu_op,
    input  logic [5:0]       funct,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [4:0]       shamt,
    output logic [3:0]       alu_ctrl,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             overflow,
    input  logic [WIDTH-1:0] add_a,
    input  logic [WIDTH-1:0] add_b,
    output logic [WIDTH-1:0] add_sum
);

    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_OR   = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_XOR  = 4'b0011;
    localparam logic [3:0] OP_SUB  = 4'b0110;
    localparam logic [3:0] OP_SLT  = 4'b0111;
    localparam logic [3:0] OP_SLL  = 4'b1000;
    localparam logic [3:0] OP_SRL  = 4'b1001;
    localparam logic [3:0] OP_SRA  = 4'b1010;
    localparam logic [3:0] OP_SLTU = 4'b1011;
    localparam logic [3:0] OP_NOR  = 4'b1100;
    localparam logic [3:0] OP_NOP  = 4'b1111;

    logic [3:0]       ctrl_next;
    logic             signed_op;
    logic [WIDTH-1:0] add_res;
    logic [WIDTH-1:0] sub_res;
    logic             ovf_add;
    logic             ovf_sub;
    logic             slt_lt;
    logic [WIDTH-1:0] res_next;
    logic             ovf_next;

    // signed_op marks the trapping add/sub forms; the unsigned forms share the datapath
    always_comb begin
        ctrl_next = OP_NOP;
        signed_op = 1'b0;
        case (alu_op)
            2'b00: begin
                ctrl_next = OP_ADD;
                signed_op = 1'b1;
            end
            2'b01: begin
                ctrl_next = OP_SUB;
                signed_op = 1'b1;
            end
            2'b10: begin
                case (funct)
                    6'b100000: begin
                        ctrl_next = OP_ADD;
                        signed_op = 1'b1;
                    end
                    6'b100001: ctrl_next = OP_ADD;
                    6'b100010: begin
                        ctrl_next = OP_SUB;
                        signed_op = 1'b1;
                    end
                    6'b100011: ctrl_next = OP_SUB;
                    6'b100100: ctrl_next = OP_AND;
                    6'b100101: ctrl_next = OP_OR;
                    6'b100111: ctrl_next = OP_NOR;
                    6'b101010: ctrl_next = OP_SLT;
                    6'b000000: ctrl_next = OP_SLL;
                    6'b000010: ctrl_next = OP_SRL;
`ifdef ALU_EXT_OPS_EN
                    6'b100110: ctrl_next = OP_XOR;
                    6'b000011: ctrl_next = OP_SRA;
                    6'b101011: ctrl_next = OP_SLTU;
`endif
                    default:   ctrl_next = OP_NOP;
                endcase
            end
            default: ctrl_next = OP_NOP;
        endcase
    end

    assign add_res = a + b;
    assign sub_res = a - b;
    assign ovf_add = (a[WIDTH-1] == b[WIDTH-1]) && (add_res[WIDTH-1] != a[WIDTH-1]);
    assign ovf_sub = (a[WIDTH-1] != b[WIDTH-1]) && (sub_res[WIDTH-1] != a[WIDTH-1]);
    assign slt_lt  = ($signed(a) < $signed(b));

    always_comb begin
        res_next = '0;
        case (ctrl_next)
            OP_AND:  res_next = a & b;
            OP_OR:   res_next = a | b;
            OP_ADD:  res_next = add_res;
            OP_SUB:  res_next = sub_res;
            OP_SLT:  res_next = {{(WIDTH-1){1'b0}}, slt_lt};
            OP_NOR:  res_next = ~(a | b);
            OP_SLL:  res_next = b << shamt;
            OP_SRL:  res_next = b >> shamt;
`ifdef ALU_EXT_OPS_EN
            OP_XOR:  res_next = a ^ b;
            OP_SRA:  res_next = $signed(b) >>> shamt;
            OP_SLTU: res_next = {{(WIDTH-1){1'b0}}, (a < b)};
`endif
            default: res_next = '0;
        endcase
    end

    assign ovf_next = signed_op && (((ctrl_next == OP_ADD) && ovf_add) ||
                                    ((ctrl_next == OP_SUB) && ovf_sub));

    // zero derives from res_next so it lands on the same edge as result
    always_ff @(posedge clk) begin
        if (!reset) begin
            alu_ctrl <= 4'b0000;
            result   <= '0;
            zero     <= 1'b0;
            overflow <= 1'b0;
        end else begin
            alu_ctrl <= ctrl_next;
            result   <= res_next;
            zero     <= (res_next == '0);
            overflow <= ovf_next;
        end
    end

    assign add_sum = add_a + add_b;

endmodule

// File: tb/tb_alu32_bit.sv
// Directed bench for alu32_bit: expected outputs queued at issue, popped and asserted one edge later.
`timescale 1ns/1ps
module tb_alu32_bit;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  alu_op;
    logic [5:0]  funct;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  shamt;
    logic [3:0]  alu_ctrl;
    logic [31:0] result;
    logic        zero;
    logic        overflow;
    logic [31:0] add_a;
    logic [31:0] add_b;
    logic [31:0] add_sum;

    int tests = 0;
    int fails = 0;

    typedef struct {
        string       tag;
        logic [3:0]  ctrl;
        logic [31:0] res;
        logic        z;
        logic        ov;
    } exp_t;

    exp_t sb[$];

    alu32_bit #(.WIDTH(32)) dut (
        .clk      (clk),
        .reset    (reset),
        .alu_op   (alu_op),
        .funct    (funct),
        .a        (a),
        .b        (b),
        .shamt    (shamt),
        .alu_ctrl (alu_ctrl),
        .result   (result),
        .zero     (zero),
        .overflow (overflow),
        .add_a    (add_a),
        .add_b    (add_b),
        .add_sum  (add_sum)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, tests=%0d", tests);
        $fatal(1, "watchdog");
    end

    task automatic push_exp(input string tag, input logic [3:0] c, input logic [31:0] r,
                            input logic z, input logic ov);
        exp_t e;
        e.tag  = tag;
        e.ctrl = c;
        e.res  = r;
        e.z    = z;
        e.ov   = ov;
        sb.push_back(e);
    endtask

    task automatic check_out();
        exp_t e;
        tests++;
        assert (sb.size() != 0) else begin
            fails++;
            $error("FAIL scoreboard_empty got %0d entries required >0", sb.size());
        end
        if (sb.size() != 0) begin
            e = sb.pop_front();
            tests++;
            assert (alu_ctrl === e.ctrl) else begin
                fails++;
                $error("FAIL %s alu_ctrl got %b required %b", e.tag, alu_ctrl, e.ctrl);
            end
            tests++;
            assert (result === e.res) else begin
                fails++;
                $error("FAIL %s result got %h required %h", e.tag, result, e.res);
            end
            tests++;
            assert (zero === e.z) else begin
                fails++;
                $error("FAIL %s zero got %b required %b", e.tag, zero, e.z);
            end
            tests++;
            assert (overflow === e.ov) else begin
                fails++;
                $error("FAIL %s overflow got %b required %b", e.tag, overflow, e.ov);
            end
        end
    endtask

    task automatic issue(input string tag, input logic [1:0] op, input logic [5:0] fn,
                         input logic [31:0] ia, input logic [31:0] ib, input logic [4:0] sh,
                         input logic [3:0] ec, input logic [31:0] er, input logic eov);
        @(negedge clk);
        alu_op = op;
        funct  = fn;
        a      = ia;
        b      = ib;
        shamt  = sh;
        push_exp(tag, ec, er, (er == 32'h0), eov);
        @(posedge clk);
        #1;
        check_out();
    endtask

    task automatic check_sum(input string tag, input logic [31:0] exp_sum);
        tests++;
        assert (add_sum === exp_sum) else begin
            fails++;
            $error("FAIL %s add_sum got %h required %h", tag, add_sum, exp_sum);
        end
    endtask

    initial begin
        reset  = 1'b0;
        alu_op = 2'b10;
        funct  = 6'b100000;
        a      = 32'd5;
        b      = 32'd7;
        shamt  = 5'd0;
        add_a  = 32'h0000_0004;
        add_b  = 32'h0000_0040;

        // reset held for two edges with an add presented
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            push_exp("reset", 4'b0000, 32'h0, 1'b0, 1'b0);
            @(posedge clk);
            #1;
            check_out();
        end
        @(negedge clk);
        reset = 1'b1;
        push_exp("reset_release_add", 4'b0010, 32'd12, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        check_out();

        issue("add_op00",   2'b00, 6'b000000, 32'h0000_0010, 32'hFFFF_FFFC, 5'd0, 4'b0010, 32'h0000_000C, 1'b0);
        issue("sub_op01",   2'b01, 6'b000000, 32'h0000_1234, 32'h0000_1234, 5'd0, 4'b0110, 32'h0,        1'b0);
        issue("add_after0", 2'b10, 6'b100001, 32'h0000_0001, 32'h0000_0002, 5'd0, 4'b0010, 32'h0000_0003, 1'b0);
        issue("add_ovf",    2'b10, 6'b100000, 32'h7FFF_FFFF, 32'h0000_0001, 5'd0, 4'b0010, 32'h8000_0000, 1'b1);
        issue("addu_noovf", 2'b10, 6'b100001, 32'h7FFF_FFFF, 32'h0000_0001, 5'd0, 4'b0010, 32'h8000_0000, 1'b0);
        issue("op00_ovf",   2'b00, 6'b111111, 32'h7FFF_FFFF, 32'h0000_0001, 5'd0, 4'b0010, 32'h8000_0000, 1'b1);
        issue("sub_ovf",    2'b10, 6'b100010, 32'h8000_0000, 32'h0000_0001, 5'd0, 4'b0110, 32'h7FFF_FFFF, 1'b1);
        issue("subu_noovf", 2'b10, 6'b100011, 32'h8000_0000, 32'h0000_0001, 5'd0, 4'b0110, 32'h7FFF_FFFF, 1'b0);
        issue("sub_noovf",  2'b10, 6'b100010, 32'h0000_0005, 32'h0000_0007, 5'd0, 4'b0110, 32'hFFFF_FFFE, 1'b0);
        issue("and",        2'b10, 6'b100100, 32'h0000_F0F0, 32'h0000_FF00, 5'd0, 4'b0000, 32'h0000_F000, 1'b0);
        issue("or",         2'b10, 6'b100101, 32'h0000_F0F0, 32'h0000_FF00, 5'd0, 4'b0001, 32'h0000_FFF0, 1'b0);
        issue("nor",        2'b10, 6'b100111, 32'h0,         32'h0,         5'd0, 4'b1100, 32'hFFFF_FFFF, 1'b0);
        issue("slt_true",   2'b10, 6'b101010, 32'hFFFF_FFFF, 32'h0000_0001, 5'd0, 4'b0111, 32'h0000_0001, 1'b0);
        issue("slt_false",  2'b10, 6'b101010, 32'h0000_0001, 32'hFFFF_FFFF, 5'd0, 4'b0111, 32'h0,        1'b0);
        issue("sll31",      2'b10, 6'b000000, 32'h0,         32'h0000_0001, 5'd31, 4'b1000, 32'h8000_0000, 1'b0);
        issue("sll0_pass",  2'b10, 6'b000000, 32'h0,         32'hA5A5_1234, 5'd0, 4'b1000, 32'hA5A5_1234, 1'b0);
        issue("srl4",       2'b10, 6'b000010, 32'h0,         32'h8000_0000, 5'd4, 4'b1001, 32'h0800_0000, 1'b0);
        issue("funct_unk",  2'b10, 6'b111111, 32'h0000_0003, 32'h0000_0004, 5'd0, 4'b1111, 32'h0,        1'b0);
        issue("op11_nop",   2'b11, 6'b100000, 32'h0000_0003, 32'h0000_0004, 5'd0, 4'b1111, 32'h0,        1'b0);
`ifdef ALU_EXT_OPS_EN
        issue("sra4",       2'b10, 6'b000011, 32'h0,         32'h8000_0000, 5'd4, 4'b1010, 32'hF800_0000, 1'b0);
        issue("sltu",       2'b10, 6'b101011, 32'h0000_0001, 32'hFFFF_FFFF, 5'd0, 4'b1011, 32'h0000_0001, 1'b0);
        issue("xor",        2'b10, 6'b100110, 32'h0000_FF00, 32'h0000_0FF0, 5'd0, 4'b0011, 32'h0000_F0F0, 1'b0);
`else
        issue("sra4_off",   2'b10, 6'b000011, 32'h0,         32'h8000_0000, 5'd4, 4'b1111, 32'h0,        1'b0);
        issue("sltu_off",   2'b10, 6'b101011, 32'h0000_0001, 32'hFFFF_FFFF, 5'd0, 4'b1111, 32'h0,        1'b0);
        issue("xor_off",    2'b10, 6'b100110, 32'h0000_FF00, 32'h0000_0FF0, 5'd0, 4'b1111, 32'h0,        1'b0);
`endif

        // free-standing adder: same-cycle response, immune to clock and reset
        @(negedge clk);
        add_a = 32'h0000_0004;
        add_b = 32'h0000_0040;
        #1;
        check_sum("sum_pc4", 32'h0000_0044);
        add_a = 32'hFFFF_FFFC;
        add_b = 32'h0000_0004;
        #1;
        check_sum("sum_wrap", 32'h0);
        add_a = 32'h1234_5678;
        add_b = 32'h1111_1111;
        #1;
        check_sum("sum_pre_reset", 32'h2345_6789);
        reset = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            #1;
            check_sum("sum_in_reset", 32'h2345_6789);
        end
        @(negedge clk);
        push_exp("reset_again", 4'b0000, 32'h0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        check_out();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/alu32_bit.md
Name: alu32_bit

Overview:
- Execute-stage arithmetic block of the single-cycle MIPS datapath.
- Three parts:
  - ALU-control decoder: maps 2-bit ALUOp plus 6-bit funct to a 4-bit operation code.
  - 32-bit ALU: registered result, zero and overflow flags.
  - Free-standing combinational 32-bit adder, used for PC+4 and branch-target computation.

Parameters:
- WIDTH, 32, datapath width of ALU and adder; the only supported value is 32.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-low reset
- alu_op  input  2  ALUOp from control unit
- funct  input  6  instruction[5:0]
- a  input  32  operand A (rs data)
- b  input  32  operand B (rt data or sign-extended immediate)
- shamt  input  5  shift amount
- alu_ctrl  output  4  registered decoded operation code
- result  output  32  registered ALU result
- zero  output  1  registered, 1 when result == 0
- overflow  output  1  registered signed overflow flag
- add_a  input  32  adder operand
- add_b  input  32  adder operand
- add_sum  output  32  combinational add_a + add_b

Behaviour:
- Decode (combinational, internal):
  - alu_op 00 -> 0010 ADD
  - alu_op 01 -> 0110 SUB
  - alu_op 11 -> 1111 NOP
  - alu_op 10 -> decode funct:
    - 100000/100001 -> 0010 ADD
    - 100010/100011 -> 0110 SUB
    - 100100 -> 0000 AND
    - 100101 -> 0001 OR
    - 100111 -> 1100 NOR
    - 101010 -> 0111 SLT
    - 000000 -> 1000 SLL
    - 000010 -> 1001 SRL
    - 100110 -> 0011 XOR (ext)
    - 000011 -> 1010 SRA (ext)
    - 101011 -> 1011 SLTU (ext)
    - any other funct -> 1111
- ALU operations:
  - ADD/SUB: modulo 2^32.
  - SLT: signed compare; result is 1 or 0.
  - SLTU: unsigned compare; result is 1 or 0.
  - Shifts act on b by shamt; SRA is arithmetic. shamt 0 passes b through.
  - Code 1111: result = 0.
- Overflow:
  - Set only for ADD/SUB when funct or alu_op selects the signed form (alu_op 00/01, funct 100000/100010).
  - ADD: operands have equal signs and the result sign differs.
  - SUB: operands have differing signs and the result sign differs from a.
  - addu/subu and all other ops: 0. The result is still written when overflow is set.
- Timing:
  - Inputs are sampled at the rising edge of clk.
  - alu_ctrl, result, zero and overflow update together one cycle later.
  - No handshake; a new operation may be issued every cycle.
- zero is computed from the new result value in the same edge, never lagging a cycle.
- Reset:
  - When reset == 0 at a rising edge: alu_ctrl = 0000, result = 0, zero = 0, overflow = 0.
  - Reset overrides any operation presented in that cycle.
  - Operation resumes at the first edge with reset == 1.
- add_sum: purely combinational, wraps modulo 2^32, no carry out, unaffected by clk and reset.
- The decoder and adder contain no X-propagating defaults; all case statements are fully covered.

Optional Feature:
- Macro ALU_EXT_OPS_EN.
- Defined: XOR (0011), SRA (1010) and SLTU (1011) are decoded and executed as above.
- Undefined:
  - funct 100110, 000011 and 101011 decode to 1111, giving result 0, overflow 0, zero 1.
  - The corresponding datapath logic is absent.

Test Plan:
- Reset: hold reset = 0 for 2 edges with alu_op 10, funct 100000, a = 5, b = 7 -> result 0, zero 0, overflow 0, alu_ctrl 0000. Release reset; the next edge gives result 12.
- Arithmetic:
  - alu_op 00, a = 0x00000010, b = 0xFFFFFFFC -> result 0x0000000C, alu_ctrl 0010.
  - alu_op 01, a = b = 0x1234 -> result 0, zero 1.
- Overflow:
  - funct 100000, a = 0x7FFFFFFF, b = 1 -> result 0x80000000, overflow 1.
  - Same operands with funct 100001 -> overflow 0.
  - funct 100010, a = 0x80000000, b = 1 -> overflow 1.
- Logic, compare and shift:
  - AND 0xF0F0 & 0xFF00 = 0xF000.
  - NOR of 0 and 0 = 0xFFFFFFFF.
  - SLT a = -1, b = 1 -> 1.
  - SLL b = 1, shamt = 31 -> 0x80000000.
  - SRL b = 0x80000000, shamt = 4 -> 0x08000000.
  - Unknown funct 111111 -> alu_ctrl 1111, result 0.
- Extended ops:
  - With ALU_EXT_OPS_EN: SRA b = 0x80000000, shamt = 4 -> 0xF8000000; SLTU a = 1, b = 0xFFFFFFFF -> 1.
  - Without ALU_EXT_OPS_EN: the same stimulus gives result 0, alu_ctrl 1111.
- Adder:
  - add_a = 0x00000004, add_b = 0x00000040 -> add_sum 0x00000044 in the same cycle.
  - add_a = 0xFFFFFFFC, add_b = 4 -> add_sum 0.
  - Output is unchanged while reset is asserted.
